// File: rtl/display_scan.sv
// display_scan -- four-digit multiplexed 7-segment scanner.
//
// Purpose:
//   Takes a slow scan clock from the LED divider, treats it as data
//   (synchronized and edge-detected), and on every rising edge steps to the
//   next of four digits. Each step first blanks all anodes for at least one
//   cycle, then drives the new digit. Digits can be blanked or blinked
//   individually. The blink phase is shared by all digits and toggles every
//   BLINK_STEPS scan steps.
//
// Ports:
//   clk         system clock. All state changes on its rising edge.
//   reset       synchronous, active-low reset.
//   clk_leds    divided scan clock. Asynchronous to clk and used only as data.
//   digits      four BCD nibbles. digits[4i+3:4i] belongs to digit i.
//   blank_mask  bit i=1 forces digit i dark.
//   blink_en    bit i=1 makes digit i blink.
//   dots        bit i=1 lights the decimal point of digit i.
//   an          active-low digit enables.
//   seg         active-low segments {g,f,e,d,c,b,a}.
//   dp          active-low decimal point.
//   scan_tick   one-cycle pulse per accepted scan step.

module display_scan #(
    parameter int BLINK_STEPS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_leds,
    input  logic [15:0] digits,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  blink_en,
    input  logic [3:0]  dots,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        scan_tick
);

    localparam logic [15:0] LP_BLINK_LAST = 16'(BLINK_STEPS - 1);

    // ST_BLANK: anodes are off and a digit load is pending for r_idx.
    typedef enum logic {ST_SHOW, ST_BLANK} state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic        r_scan_tick;
    logic        w_step;

    logic [1:0]  r_idx;
    logic [15:0] r_blink_cnt;
    logic        r_blink_phase;
    logic        r_load_phase;

    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_dp;

    logic [3:0]  w_nibble;
    logic        w_dark;
    logic [6:0]  w_seg_dec;
    logic [3:0]  w_an_load;

    assign w_step = r_sync2 & ~r_prev;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_SHOW;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A step always (re)enters the blank state, including a step that
    // arrives while a load is still pending. That step extends the blanking.
    always_comb begin
        w_state_next = r_state;
        if (r_scan_tick) begin
            w_state_next = ST_BLANK;
        end else if (r_state == ST_BLANK) begin
            w_state_next = ST_SHOW;
        end
    end

    // Load-time decode for the digit selected by r_idx
    assign w_nibble = digits[{r_idx, 2'b00} +: 4];
    assign w_dark   = blank_mask[r_idx] | (blink_en[r_idx] & r_load_phase);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_an
            assign w_an_load[gi] = (r_idx != 2'(gi));
        end
    endgenerate

    always_comb begin
        w_seg_dec = 7'b0111111;
        case (w_nibble)
            4'd0:    w_seg_dec = 7'b1000000;
            4'd1:    w_seg_dec = 7'b1111001;
            4'd2:    w_seg_dec = 7'b0100100;
            4'd3:    w_seg_dec = 7'b0110000;
            4'd4:    w_seg_dec = 7'b0011001;
            4'd5:    w_seg_dec = 7'b0010010;
            4'd6:    w_seg_dec = 7'b0000010;
            4'd7:    w_seg_dec = 7'b1111000;
            4'd8:    w_seg_dec = 7'b0000000;
            4'd9:    w_seg_dec = 7'b0010000;
            default: w_seg_dec = 7'b0111111;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_prev        <= 1'b0;
            r_scan_tick   <= 1'b0;
            r_idx         <= 2'd0;
            r_blink_cnt   <= 16'd0;
            r_blink_phase <= 1'b0;
            r_load_phase  <= 1'b0;
            r_an          <= 4'b1111;
            r_seg         <= 7'b1111111;
            r_dp          <= 1'b1;
        end else begin
            r_sync1     <= clk_leds;
            r_sync2     <= r_sync1;
            r_prev      <= r_sync2;
            r_scan_tick <= w_step;

            if (r_scan_tick) begin
                r_idx <= r_idx + 2'd1;
                r_an  <= 4'b1111;
                // The digit loaded for this step uses the phase of the
                // interval the step belongs to, captured before the wrap.
                r_load_phase <= r_blink_phase;
                if (r_blink_cnt == LP_BLINK_LAST) begin
                    r_blink_cnt   <= 16'd0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 16'd1;
                end
            end else if (r_state == ST_BLANK) begin
                r_an  <= w_an_load;
                r_seg <= w_dark ? 7'b1111111 : w_seg_dec;
                r_dp  <= w_dark ? 1'b1 : ~dots[r_idx];
            end
        end
    end

    assign an        = r_an;
    assign seg       = r_seg;
    assign dp        = r_dp;
    assign scan_tick = r_scan_tick;

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan -- scoreboard bench for display_scan.
// Stimulus pushes the expected digit load into a queue. A monitor pops it
// whenever the anodes come back on after a blank cycle and compares it.

module tb_display_scan;

    localparam int BLINK = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_leds = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  blank_mask = 4'b0000;
    logic [3:0]  blink_en = 4'b0000;
    logic [3:0]  dots = 4'b0000;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        scan_tick;

    display_scan #(.BLINK_STEPS(BLINK)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_leds   (clk_leds),
        .digits     (digits),
        .blank_mask (blank_mask),
        .blink_en   (blink_en),
        .dots       (dots),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .scan_tick  (scan_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         blank_len;   // 0 = not checked
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int   m_idx = 0;
    int   m_cnt = 0;
    bit   m_phase = 1'b0;
    bit   m_after_rst = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic model_reset();
        m_idx = 0;
        m_cnt = 0;
        m_phase = 1'b0;
        m_after_rst = 1'b1;
    endtask

    // One step of the reference model; pushes the digit that must appear.
    task automatic push_step();
        exp_t       e;
        bit         lp;
        bit         dark;
        logic [3:0] one;
        one   = 4'b0001;
        m_idx = (m_idx + 1) % 4;
        lp    = m_phase;
        if (m_cnt == BLINK - 1) begin
            m_cnt   = 0;
            m_phase = ~m_phase;
        end else begin
            m_cnt++;
        end
        dark        = blank_mask[m_idx] | (blink_en[m_idx] & lp);
        e.an        = ~(one << m_idx);
        e.seg       = dark ? 7'b1111111 : enc(digits[m_idx*4 +: 4]);
        e.dp        = dark ? 1'b1 : ~dots[m_idx];
        e.blank_len = m_after_rst ? 0 : 1;
        m_after_rst = 1'b0;
        q.push_back(e);
    endtask

    // scan_tick must be low after the first two edges and high after the third.
    task automatic check_tick(input string name);
        @(posedge clk); #1;
        chk({name, "_tick_e1"}, 32'(scan_tick), 32'd0);
        @(posedge clk); #1;
        chk({name, "_tick_e2"}, 32'(scan_tick), 32'd0);
        @(posedge clk); #1;
        chk({name, "_tick_e3"}, 32'(scan_tick), 32'd1);
    endtask

    task automatic apply_reset(input logic leds_at_release);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            clk_leds = ~clk_leds;
            @(posedge clk); #1;
            chk("rst_an", 32'(an), 32'hf);
            chk("rst_seg", 32'(seg), 32'h7f);
            chk("rst_dp", 32'(dp), 32'd1);
            chk("rst_tick", 32'(scan_tick), 32'd0);
        end
        clk_leds = leds_at_release;
        reset = 1'b1;
        q.delete();
        model_reset();
        if (leds_at_release) begin
            push_step();
            check_tick("release");
            clk_leds = 1'b0;
            repeat (5) @(posedge clk);
            #1;
        end else begin
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    task automatic do_step(input bit rst_pulse);
        clk_leds = 1'b1;
        push_step();
        check_tick("step");
        clk_leds = 1'b0;
        if (rst_pulse) begin
            @(posedge clk); #1;       // in the blank cycle now
            reset = 1'b0;
            @(posedge clk); #1;
            reset = 1'b1;
            chk("rst_in_blank_an", 32'(an), 32'hf);
            void'(q.pop_back());
            model_reset();
            repeat (5) @(posedge clk);
            #1;
        end else begin
            repeat (5) @(posedge clk);
            #1;
        end
    endtask

    // Two rising edges as close together as the synchronizer allows.
    task automatic do_fast();
        clk_leds = 1'b1;
        push_step();
        @(posedge clk); #1;
        clk_leds = 1'b0;
        @(posedge clk); #1;
        clk_leds = 1'b1;
        push_step();
        @(posedge clk); #1;
        chk("fast_tick1", 32'(scan_tick), 32'd1);
        clk_leds = 1'b0;
        @(posedge clk); #1;
        chk("fast_gap", 32'(scan_tick), 32'd0);
        @(posedge clk); #1;
        chk("fast_tick2", 32'(scan_tick), 32'd1);
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Monitor: a load is an anode pattern appearing right after all-off.
    logic [3:0] prev_an = 4'hf;
    int         blank_run = 0;
    exp_t       me;

    always @(negedge clk) begin
        if (!$isunknown(an)) begin
            if (an == 4'hf) begin
                blank_run++;
            end else if (prev_an == 4'hf) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_load: got an=%b seg=%b dp=%b, required no load", an, seg, dp);
                end else begin
                    me = q.pop_front();
                    $display("load an=%b seg=%b dp=%b blank=%0d (required an=%b seg=%b dp=%b)",
                             an, seg, dp, blank_run, me.an, me.seg, me.dp);
                    chk("load", 32'({an, seg, dp}), 32'({me.an, me.seg, me.dp}));
                    if (me.blank_len != 0) chk("blank_len", 32'(blank_run), 32'(me.blank_len));
                end
                blank_run = 0;
            end else if (an != prev_an) begin
                n_checks++;
                n_fail++;
                $display("FAIL break_before_make: got an %b -> %b, required a 1111 cycle between", prev_an, an);
            end
            prev_an = an;
        end
    end

    initial begin
        // Reset with clk_leds toggling; release with clk_leds low
        apply_reset(1'b0);

        // Basic scan through all digits
        digits = 16'h3210;
        for (int i = 0; i < 5; i++) do_step(1'b0);

        // Dash for a non-BCD nibble and the decimal point on digit 1
        digits = 16'h32C0;
        dots   = 4'b0010;
        for (int i = 0; i < 4; i++) do_step(1'b0);
        dots   = 4'b0000;

        // Forced blank on digit 2
        blank_mask = 4'b0100;
        digits     = 16'h9765;
        for (int i = 0; i < 4; i++) do_step(1'b0);
        blank_mask = 4'b0000;

        // Blink on digit 0 over three blink half-periods
        apply_reset(1'b0);
        blink_en = 4'b0001;
        digits   = 16'h8888;
        for (int i = 0; i < 12; i++) do_step(1'b0);
        blink_en = 4'b0000;

        // Reset in the blank cycle after the third step
        apply_reset(1'b0);
        digits = 16'h3210;
        do_step(1'b0);
        do_step(1'b0);
        do_step(1'b1);
        do_step(1'b0);

        // clk_leds high at reset release counts as a rising edge
        apply_reset(1'b1);

        // Back-to-back steps
        do_fast();

        repeat (10) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
